perf_test_sequencer: RTL and testbench

Iteration controller for the host-memory performance-test kernel: launches the read and write master engines repeatedly according to a programmed mode and loop count, waits for their done pulses, and accumulates cycle statistics and error status. Sits between the AXI-Lite register hub and the read/write master engines, and replaces the single shared engine start pulse with per-engine start pulses.

---
 rtl/perf_seq_pkg.sv | 31 +++
 rtl/perf_seq_sat_cnt.sv | 30 +++
 rtl/perf_test_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_perf_test_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_seq_pkg.sv
// Shared types and encodings for the perf-test iteration sequencer.
package perf_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StNext,
    StDone
  } seq_state_e;

  localparam logic [1:0] MODE_RD     = 2'b00;
  localparam logic [1:0] MODE_WR     = 2'b01;
  localparam logic [1:0] MODE_SERIAL = 2'b10;
  localparam logic [1:0] MODE_CONC   = 2'b11;

  localparam int unsigned ERR_RD      = 0;
  localparam int unsigned ERR_WR      = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  // Engines launched for a mode/phase, packed as {wr, rd}.
  function automatic logic [1:0] launch_mask(input logic [1:0] mode, input logic phase);
    case (mode)
      MODE_RD:     return 2'b01;
      MODE_WR:     return 2'b10;
      MODE_SERIAL: return phase ? 2'b10 : 2'b01;
      default:     return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/perf_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module perf_seq_sat_cnt #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_test_sequencer.sv
// Iteration controller: launches read/write engines per mode and loop count, gathers stats.
// Define PERF_SEQ_TIMEOUT_EN to add the per-iteration WAIT watchdog (seq_error bit2).
module perf_test_sequencer
  import perf_seq_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned ITER_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  seq_start_pulse,
  input  logic [1:0]            seq_mode,
  input  logic [ITER_WIDTH-1:0] loop_count,
  input  logic [31:0]           timeout_cycles,
  input  logic                  rd_done_pulse,
  input  logic [1:0]            rd_error,
  input  logic                  wr_done_pulse,
  input  logic                  wr_error,
  output logic                  rd_start_pulse,
  output logic                  wr_start_pulse,
  output logic                  seq_busy,
  output logic                  seq_done_pulse,
  output logic [2:0]            seq_error,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [CNT_WIDTH-1:0]  total_cycles,
  output logic [CNT_WIDTH-1:0]  rd_cycles,
  output logic [CNT_WIDTH-1:0]  wr_cycles
);

  seq_state_e            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ITER_WIDTH-1:0] loop_q, loop_d, iter_q, iter_d, iter_inc;
  logic                  phase_q, phase_d;
  logic                  rd_flag_q, rd_flag_d, wr_flag_q, wr_flag_d;
  logic                  rd_start_q, rd_start_d, wr_start_q, wr_start_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [2:0]            err_q, err_d, err_nx;
  logic [1:0]            need;
  logic                  rd_hit, wr_hit, all_fin, start_acc;
  logic                  total_en, rd_en, wr_en;

`ifdef PERF_SEQ_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_hit;
  assign timeout_hit = (timeout_cycles != 32'd0) && ((wd_q + 32'd1) == timeout_cycles);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
`endif

  assign need      = launch_mask(mode_q, phase_q);
  assign iter_inc  = iter_q + ITER_WIDTH'(1);
  assign start_acc = (state_q == StIdle) && seq_start_pulse;
  // Only the first done from an engine launched in this phase counts.
  assign rd_hit    = (state_q == StWait) && rd_done_pulse && need[0] && !rd_flag_q;
  assign wr_hit    = (state_q == StWait) && wr_done_pulse && need[1] && !wr_flag_q;
  assign all_fin   = (rd_flag_q | rd_hit | ~need[0]) & (wr_flag_q | wr_hit | ~need[1]);

  always_comb begin
    err_nx = err_q;
    if (rd_hit && (rd_error != 2'b00)) err_nx[ERR_RD] = 1'b1;
    if (wr_hit && wr_error)            err_nx[ERR_WR] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    loop_d     = loop_q;
    iter_d     = iter_q;
    phase_d    = phase_q;
    rd_flag_d  = rd_flag_q;
    wr_flag_d  = wr_flag_q;
    busy_d     = busy_q;
    err_d      = err_q;
    rd_start_d = 1'b0;
    wr_start_d = 1'b0;
    done_d     = 1'b0;
`ifdef PERF_SEQ_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      StIdle: begin
        if (seq_start_pulse) begin
          mode_d  = seq_mode;
          loop_d  = loop_count;
          iter_d  = '0;
          err_d   = '0;
          phase_d = 1'b0;
          if (loop_count == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StLaunch;
            busy_d  = 1'b1;
            {wr_start_d, rd_start_d} = launch_mask(seq_mode, 1'b0);
          end
        end
      end
      StLaunch: begin
        rd_flag_d = 1'b0;
        wr_flag_d = 1'b0;
        state_d   = StWait;
`ifdef PERF_SEQ_TIMEOUT_EN
        wd_d      = '0;
`endif
      end
      StWait: begin
        rd_flag_d = rd_flag_q | rd_hit;
        wr_flag_d = wr_flag_q | wr_hit;
        err_d     = err_nx;
`ifdef PERF_SEQ_TIMEOUT_EN
        wd_d      = wd_q + 32'd1;
`endif
        if (all_fin) begin
          if (err_nx != '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if ((mode_q == MODE_SERIAL) && !phase_q) begin
            phase_d    = 1'b1;
            state_d    = StLaunch;
            wr_start_d = 1'b1;
          end else begin
            state_d = StNext;
          end
        end
`ifdef PERF_SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = StDone;
          done_d             = 1'b1;
          busy_d             = 1'b0;
        end
`endif
      end
      StNext: begin
        iter_d = iter_inc;
        if (iter_inc == loop_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = StLaunch;
          phase_d = 1'b0;
          {wr_start_d, rd_start_d} = launch_mask(mode_q, 1'b0);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      loop_q     <= '0;
      iter_q     <= '0;
      phase_q    <= 1'b0;
      rd_flag_q  <= 1'b0;
      wr_flag_q  <= 1'b0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
`ifdef PERF_SEQ_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      loop_q     <= loop_d;
      iter_q     <= iter_d;
      phase_q    <= phase_d;
      rd_flag_q  <= rd_flag_d;
      wr_flag_q  <= wr_flag_d;
      rd_start_q <= rd_start_d;
      wr_start_q <= wr_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PERF_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  // An engine is outstanding from its launch cycle through its done cycle.
  assign total_en = (state_q == StLaunch) || (state_q == StWait) || (state_q == StNext);
  assign rd_en    = need[0] && ((state_q == StLaunch) || ((state_q == StWait) && !rd_flag_q));
  assign wr_en    = need[1] && ((state_q == StLaunch) || ((state_q == StWait) && !wr_flag_q));

  perf_seq_sat_cnt #(.Width(CNT_WIDTH)) u_total_cnt (
    .clk_i (clk),
    .rst_ni(resetn),
    .clr_i (start_acc),
    .en_i  (total_en),
    .cnt_o (total_cycles)
  );

  perf_seq_sat_cnt #(.Width(CNT_WIDTH)) u_rd_cnt (
    .clk_i (clk),
    .rst_ni(resetn),
    .clr_i (start_acc),
    .en_i  (rd_en),
    .cnt_o (rd_cycles)
  );

  perf_seq_sat_cnt #(.Width(CNT_WIDTH)) u_wr_cnt (
    .clk_i (clk),
    .rst_ni(resetn),
    .clr_i (start_acc),
    .en_i  (wr_en),
    .cnt_o (wr_cycles)
  );

  assign rd_start_pulse = rd_start_q;
  assign wr_start_pulse = wr_start_q;
  assign seq_busy       = busy_q;
  assign seq_done_pulse = done_q;
  assign seq_error      = err_q;
  assign iter_count     = iter_q;

endmodule

// File: tb/tb_perf_test_sequencer.sv
// Scoreboard bench for perf_test_sequencer: a timing model queues expected pulses per run.
module tb_perf_test_sequencer;
  import perf_seq_pkg::*;

  logic        clk;
  logic        resetn;
  logic        seq_start_pulse;
  logic [1:0]  seq_mode;
  logic [31:0] loop_count;
  logic [31:0] timeout_cycles;
  logic        rd_done_pulse;
  logic [1:0]  rd_error;
  logic        wr_done_pulse;
  logic        wr_error;
  logic        rd_start_pulse;
  logic        wr_start_pulse;
  logic        seq_busy;
  logic        seq_done_pulse;
  logic [2:0]  seq_error;
  logic [31:0] iter_count;
  logic [63:0] total_cycles;
  logic [63:0] rd_cycles;
  logic [63:0] wr_cycles;

  perf_test_sequencer #(
    .CNT_WIDTH (64),
    .ITER_WIDTH(32)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .seq_start_pulse(seq_start_pulse),
    .seq_mode       (seq_mode),
    .loop_count     (loop_count),
    .timeout_cycles (timeout_cycles),
    .rd_done_pulse  (rd_done_pulse),
    .rd_error       (rd_error),
    .wr_done_pulse  (wr_done_pulse),
    .wr_error       (wr_error),
    .rd_start_pulse (rd_start_pulse),
    .wr_start_pulse (wr_start_pulse),
    .seq_busy       (seq_busy),
    .seq_done_pulse (seq_done_pulse),
    .seq_error      (seq_error),
    .iter_count     (iter_count),
    .total_cycles   (total_cycles),
    .rd_cycles      (rd_cycles),
    .wr_cycles      (wr_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event code is {done, wr_start, rd_start}.
  typedef struct {
    int         cyc;
    logic [2:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  bit  done_seen;
  int  rd_cnt, wr_cnt, rd_delay, wr_delay, rd_dones, wr_dones, rd_err_at, wr_err_at;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void push_ev(input int c, input logic [2:0] k);
    ev_t e;
    e.cyc  = c;
    e.code = k;
    exp_q.push_back(e);
  endfunction

  // One cycle: clear single-cycle inputs, score outputs, then play the engines.
  task automatic tick();
    logic [2:0] code;
    ev_t        ev;
    @(negedge clk);
    cyc++;
    seq_start_pulse = 1'b0;
    rd_done_pulse   = 1'b0;
    rd_error        = 2'b00;
    wr_done_pulse   = 1'b0;
    wr_error        = 1'b0;
    code = {seq_done_pulse, wr_start_pulse, rd_start_pulse};
    if (code != 3'b000) begin
      if (seq_done_pulse) begin
        done_seen = 1'b1;
        check_eq("busy_at_done", 64'(seq_busy), 64'd0);
      end
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", 64'(code), 64'd0);
      end else begin
        ev = exp_q.pop_front();
        check_eq("event_cycle", 64'(cyc), 64'(ev.cyc));
        check_eq("event_kind", 64'(code), 64'(ev.code));
      end
    end
    if (rd_cnt != 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        rd_done_pulse = 1'b1;
        rd_dones++;
        if (rd_dones == rd_err_at) rd_error = 2'b01;
      end
    end
    if (wr_cnt != 0) begin
      wr_cnt--;
      if (wr_cnt == 0) begin
        wr_done_pulse = 1'b1;
        wr_dones++;
        if (wr_dones == wr_err_at) wr_error = 1'b1;
      end
    end
    if (rd_start_pulse) rd_cnt = rd_delay;
    if (wr_start_pulse) wr_cnt = wr_delay;
  endtask

  // rdd/wrd: engine done latency after launch (0 = never answers); rea/wea: erroring done index.
  task automatic run(input string name, input logic [1:0] mode, input int loop, input int rdd,
                     input int wrd, input int rea, input int wea, input int to, input bit poke);
    int         s, t, m, rdn, wrn, dc, eit;
    logic [2:0] e;
    longint     rdc, wrc;
    rd_delay = rdd; wr_delay = wrd; rd_dones = 0; wr_dones = 0;
    rd_err_at = rea; wr_err_at = wea; rd_cnt = 0; wr_cnt = 0;
    timeout_cycles = to;
    s = cyc; t = s + 1; rdn = 0; wrn = 0; e = 3'b000; rdc = 0; wrc = 0; eit = 0; dc = s + 1;
    for (int it = 0; it < loop; it++) begin
      if (mode == MODE_RD && rdd == 0) begin
        push_ev(t, 3'b001);
        dc  = t + 1 + to;
        rdc = rdc + to + 1;
        e   = 3'b100;
        break;
      end
      case (mode)
        MODE_RD: begin
          push_ev(t, 3'b001); m = t + rdd; rdn++; rdc = rdc + rdd + 1;
          if (rdn == rea) e[0] = 1'b1;
        end
        MODE_WR: begin
          push_ev(t, 3'b010); m = t + wrd; wrn++; wrc = wrc + wrd + 1;
          if (wrn == wea) e[1] = 1'b1;
        end
        MODE_CONC: begin
          push_ev(t, 3'b011); m = t + ((rdd > wrd) ? rdd : wrd);
          rdn++; wrn++; rdc = rdc + rdd + 1; wrc = wrc + wrd + 1;
          if (rdn == rea) e[0] = 1'b1;
          if (wrn == wea) e[1] = 1'b1;
        end
        default: begin
          push_ev(t, 3'b001); m = t + rdd; rdn++; rdc = rdc + rdd + 1;
          if (rdn == rea) e[0] = 1'b1;
          if (e == 3'b000) begin
            push_ev(m + 1, 3'b010); m = m + 1 + wrd; wrn++; wrc = wrc + wrd + 1;
            if (wrn == wea) e[1] = 1'b1;
          end
        end
      endcase
      if (e != 3'b000) begin
        dc = m + 1;
        break;
      end
      eit++;
      if (it == loop - 1) dc = m + 2;
      else                t  = m + 2;
    end
    push_ev(dc, 3'b100);

    seq_mode = mode; loop_count = 32'(loop); seq_start_pulse = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 600 && !done_seen; k++) begin
      tick();
      if (k == 0 && loop != 0) check_eq({name, "_busy"}, 64'(seq_busy), 64'd1);
      if (poke && k == 4) begin
        seq_mode = MODE_CONC; loop_count = 32'd9; seq_start_pulse = 1'b1;
      end
    end
    if (!done_seen) check_eq({name, "_done_timeout"}, 64'd0, 64'd1);
    check_eq({name, "_iter"}, 64'(iter_count), 64'(eit));
    check_eq({name, "_err"}, 64'(seq_error), 64'(e));
    check_eq({name, "_total"}, total_cycles, 64'(dc - s - 1));
    check_eq({name, "_rdcyc"}, rd_cycles, 64'(rdc));
    check_eq({name, "_wrcyc"}, wr_cycles, 64'(wrc));
    repeat (4) tick();
    check_eq({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    resetn = 1'b0; seq_start_pulse = 1'b0; seq_mode = 2'b00; loop_count = 32'd0;
    timeout_cycles = 32'd0; rd_done_pulse = 1'b0; rd_error = 2'b00;
    wr_done_pulse = 1'b0; wr_error = 1'b0;
    rd_cnt = 0; wr_cnt = 0; rd_delay = 0; wr_delay = 0; rd_dones = 0; wr_dones = 0;
    rd_err_at = 0; wr_err_at = 0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(seq_busy), 64'd0);
    check_eq("rst_starts", 64'({rd_start_pulse, wr_start_pulse, seq_done_pulse}), 64'd0);
    check_eq("rst_err", 64'(seq_error), 64'd0);
    check_eq("rst_iter", 64'(iter_count), 64'd0);
    check_eq("rst_total", total_cycles, 64'd0);
    check_eq("rst_rdwr", rd_cycles | wr_cycles, 64'd0);
    resetn = 1'b1;
    tick();

    run("rd3",      MODE_RD,     3, 10, 0, 0, 0, 0, 1'b0);
    run("ser2",     MODE_SERIAL, 2, 4,  6, 0, 0, 0, 1'b0);
    run("conc_eq",  MODE_CONC,   1, 6,  6, 0, 0, 0, 1'b0);
    run("conc_skw", MODE_CONC,   1, 4,  9, 0, 0, 0, 1'b0);
    check_eq("rd_lt_wr", 64'(rd_cycles < wr_cycles), 64'd1);
    run("rd_err",   MODE_RD,     4, 5,  0, 2, 0, 0, 1'b0);
    run("wr_poke",  MODE_WR,     2, 0,  7, 0, 0, 0, 1'b1);
    run("ser_werr", MODE_SERIAL, 3, 3,  3, 0, 2, 0, 1'b0);
    run("zero",     MODE_CONC,   0, 3,  3, 0, 0, 0, 1'b0);
`ifdef PERF_SEQ_TIMEOUT_EN
    run("tmo",      MODE_RD,     1, 0,  0, 0, 0, 20, 1'b0);
`endif

    // Reset mid-WAIT, then a stray done from the aborted engine.
    rd_delay = 0; wr_delay = 0; timeout_cycles = 32'd0;
    push_ev(cyc + 1, 3'b001);
    seq_mode = MODE_RD; loop_count = 32'd2; seq_start_pulse = 1'b1;
    repeat (6) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rd_done_pulse = 1'b1; rd_error = 2'b11;
    repeat (5) tick();
    check_eq("mid_rst_busy", 64'(seq_busy), 64'd0);
    check_eq("mid_rst_err", 64'(seq_error), 64'd0);
    check_eq("mid_rst_iter", 64'(iter_count), 64'd0);
    check_eq("mid_rst_total", total_cycles, 64'd0);
    check_eq("mid_rst_rdcyc", rd_cycles, 64'd0);
    check_eq("mid_rst_pending", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
